// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the mMIPS datapath: registered single-cycle operations
// plus an iterative shift-add unsigned multiply that writes the HI/LO pair.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] CLIP_MAX = WIDTH'(255);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               valid_q, valid_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   sum, diff, aluRes;
  logic               aluOvf;
  logic [2*WIDTH-1:0] accNext;

  always_comb begin
    sum    = a + b;
    diff   = a - b;
    aluRes = '0;
    aluOvf = 1'b0;
    case (aluctrl)
      6'h00: aluRes = a & b;
      6'h01: aluRes = a | b;
      6'h02: begin
        aluRes = sum;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      6'h03: aluRes = sum;
      6'h04: aluRes = a ^ b;
      6'h06: begin
        aluRes = diff;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      6'h07: aluRes[0] = $signed(a) < $signed(b);
      6'h08: aluRes[0] = a < b;
      6'h09: aluRes = b << 16;
      6'h0A: aluRes = b << 1;
      6'h0B: aluRes = b << 2;
      6'h0C: aluRes = b << 8;
      6'h0D: aluRes = b >> 1;
      6'h0E: aluRes = b >> 2;
      6'h0F: aluRes = b >> 8;
      6'h10: aluRes = $signed(b) >>> 1;
      6'h11: aluRes = $signed(b) >>> 2;
      6'h12: aluRes = $signed(b) >>> 8;
      // Negative operands clip to 0, anything above 255 clips to 255.
      6'h30: aluRes = a[WIDTH-1] ? '0 : ((a > CLIP_MAX) ? CLIP_MAX : a);
      6'h34: aluRes = ($signed(a) < $signed(b)) ? (b - a) : diff;
      default: aluRes = '0;
    endcase
  end

  assign accNext = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (aluctrl == 6'h13) begin
            state_d  = MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
          end else begin
            result_d = aluRes;
            zero_d   = (aluRes == '0);
            ovf_d    = aluOvf;
            valid_d  = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = accNext;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The final step commits the full product in the same edge.
        if (cnt_q == LAST_STEP) begin
          hi_d     = accNext[2*WIDTH-1:WIDTH];
          lo_d     = accNext[WIDTH-1:0];
          result_d = accNext[WIDTH-1:0];
          zero_d   = (accNext[WIDTH-1:0] == '0);
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign busy      = (state_q == MUL);
  assign out_valid = valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued when a request
// is driven and popped when out_valid is seen.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  aluctrl = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, out_valid, zero, ovf;
  logic [31:0] result, hi, lo;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [97:0] obs;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluctrl(aluctrl),
    .a(a), .b(b), .busy(busy), .out_valid(out_valid), .result(result),
    .zero(zero), .ovf(ovf), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  assign obs = {result, zero, ovf, hi, lo};

  // Builds an expected entry using the bench's own view of HI/LO.
  function automatic exp_t mk(input logic [31:0] res, input logic o);
    exp_t t;
    t.res = res;
    t.z   = (res == 32'h0);
    t.o   = o;
    t.hi  = expHi;
    t.lo  = expLo;
    return t;
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; aluctrl = 6'h02; a = 32'h1; b = 32'h1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, out_valid, obs} !== 100'h0) begin
      errors++;
      $display("[TB] FAIL reset outputs=%h required 0", {busy, out_valid, obs});
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_sub;
    logic [5:0]  c[5]  = '{6'h02, 6'h06, 6'h03, 6'h07, 6'h08};
    logic [31:0] av[5] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv[5] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    logic [31:0] rv[5] = '{32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h1, 32'h0};
    logic        ov[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      aluctrl = c[i]; a = av[i]; b = bv[i]; in_valid = 1'b1;
      sb.push_back(mk(rv[i], ov[i]));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
        errors++;
        $display("[TB] FAIL add_sub[%0d] valid=%b got=%h required=%h", i, out_valid, obs, e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold valid=%b result=%h zero=%b required 0/0/1", out_valid, result, zero);
    end
  endtask

  task automatic test_shift;
    logic [5:0]  c[6]  = '{6'h12, 6'h0F, 6'h09, 6'h0C, 6'h10, 6'h0B};
    logic [31:0] bv[6] = '{32'h80000000, 32'h80000000, 32'h1234, 32'h00C00001, 32'h7FFFFFFF, 32'hC0000001};
    logic [31:0] rv[6] = '{32'hFF800000, 32'h00800000, 32'h12340000, 32'hC0000100, 32'h3FFFFFFF, 32'h00000004};
    for (int i = 0; i < 6; i++) begin
      aluctrl = c[i]; a = 32'hDEADBEEF; b = bv[i]; in_valid = 1'b1;
      sb.push_back(mk(rv[i], 1'b0));
      @(negedge clk);
      in_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
        errors++;
        $display("[TB] FAIL shift[%0d] valid=%b got=%h required=%h", i, out_valid, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clip_absdiff;
    logic [5:0]  c[5]  = '{6'h30, 6'h30, 6'h30, 6'h34, 6'h34};
    logic [31:0] av[5] = '{32'h123, 32'hFFFFFFF0, 32'h42, 32'h3, 32'hFFFFFFFE};
    logic [31:0] bv[5] = '{32'h0, 32'h0, 32'h0, 32'hA, 32'h5};
    logic [31:0] rv[5] = '{32'hFF, 32'h0, 32'h42, 32'h7, 32'h7};
    for (int i = 0; i < 5; i++) begin
      aluctrl = c[i]; a = av[i]; b = bv[i]; in_valid = 1'b1;
      sb.push_back(mk(rv[i], 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
        errors++;
        $display("[TB] FAIL clip_absdiff[%0d] valid=%b got=%h required=%h", i, out_valid, obs, e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multiply;
    int busyCnt = 0;
    int outAt = 0;
    aluctrl = 6'h13; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    expHi = 32'hFFFFFFFE; expLo = 32'h00000001;
    sb.push_back(mk(32'h1, 1'b0));
    @(negedge clk);
    // Keep requesting an AND while busy; it must be dropped.
    aluctrl = 6'h00; a = 32'h0; b = 32'h0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) busyCnt++;
      else in_valid = 1'b0;
      if (out_valid) begin
        outAt = cyc;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (busyCnt != 32) begin
      errors++;
      $display("[TB] FAIL mul_busy cycles=%0d required 32", busyCnt);
    end
    checks++;
    if (outAt != 33) begin
      errors++;
      $display("[TB] FAIL mul_latency out_valid_at=%0d required 33", outAt);
    end
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("[TB] FAIL mul_result got=%h required=%h", obs, e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mul_after valid=%b busy=%b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_illegal;
    logic [5:0] c[2] = '{6'h3F, 6'h05};
    for (int i = 0; i < 2; i++) begin
      aluctrl = c[i]; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
      sb.push_back(mk(32'h0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
        errors++;
        $display("[TB] FAIL illegal[%0d] valid=%b got=%h required=%h", i, out_valid, obs, e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_abort;
    int seen = 0;
    aluctrl = 6'h13; a = 32'h5; b = 32'h7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expHi = '0; expLo = '0;
    checks++;
    if ({busy, out_valid, result, hi, lo} !== 98'h0) begin
      errors++;
      $display("[TB] FAIL abort_state got=%h required 0", {busy, out_valid, result, hi, lo});
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_no_valid pulses=%0d busy=%b required 0/0", seen, busy);
    end
    aluctrl = 6'h02; a = 32'h2; b = 32'h3; in_valid = 1'b1;
    sb.push_back(mk(32'h5, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1 || obs !== e) begin
      errors++;
      $display("[TB] FAIL abort_add valid=%b got=%h required=%h", out_valid, obs, e);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [5:0]  ops[4] = '{6'h00, 6'h01, 6'h04, 6'h03};
    logic [31:0] ra, rb, r;
    for (int i = 0; i < 12; i++) begin
      ra = $urandom; rb = $urandom;
      aluctrl = ops[i % 4]; a = ra; b = rb; in_valid = 1'b1;
      case (i % 4)
        0: r = ra & rb;
        1: r = ra | rb;
        2: r = ra ^ rb;
        default: r = ra + rb;
      endcase
      sb.push_back(mk(r, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || obs !== e) begin
        errors++;
        $display("[TB] FAIL b2b[%0d] valid=%b got=%h required=%h", i, out_valid, obs, e);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_end valid=%b pending=%0d required 0/0", out_valid, sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_shift();
    test_clip_absdiff();
    test_multiply();
    test_illegal();
    test_mul_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU of the mMIPS datapath. It is the consumer of the 6-bit ALU control code produced by the ALU controller.
- Decodes ALUctrl and performs the operation on two 32-bit operands.
- Single-cycle ops return a registered result one cycle after acceptance. Unsigned multiply (0x13) runs as an iterative shift-add sequence into HI/LO registers, with a busy/valid handshake that lets the pipeline stall.

Parameters:
- WIDTH, 32, operand/result width; multiply iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operation request; sampled on rising edge
- aluctrl  input  6  ALU control code
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt / immediate); shifts and LUI operate on b
- busy  output  1  multiply in progress; requests are ignored while high
- out_valid  output  1  one-cycle pulse: result/flags valid
- result  output  WIDTH  registered result
- zero  output  1  result == 0, qualified by out_valid
- ovf  output  1  signed overflow of ADD (0x2) / SUB (0x6); 0 for all other codes
- hi  output  WIDTH  HI register (mfhi source)
- lo  output  WIDTH  LO register (mflo source)

Behaviour:
- Reset (rst=1 at a rising edge): busy=0, out_valid=0, result=0, zero=0, ovf=0, hi=0, lo=0, FSM goes to IDLE. Reset overrides any request. Reset mid-multiply aborts it and no out_valid is issued.
- Acceptance rule: a request is taken when in_valid=1 and busy=0 at a rising edge. in_valid while busy=1 is dropped; upstream must stall on busy.
- Single-cycle codes: accepted at edge N, result/zero/ovf registered at edge N; out_valid=1 for exactly one cycle after edge N. Back-to-back requests give one out_valid per request.
- Code map (arithmetic is mod 2^WIDTH):
  - 0x0 a&b; 0x1 a|b; 0x2 a+b signed (ovf on sign overflow, result still written); 0x3 a+b; 0x4 a^b
  - 0x6 a-b (ovf on signed overflow); 0x7 ($signed(a)<$signed(b)) ? 1 : 0; 0x8 unsigned less-than likewise
  - 0x9 b<<16
  - 0xA/0xB/0xC b<<1/2/8; 0xD/0xE/0xF b>>1/2/8 logical; 0x10/0x11/0x12 b>>>1/2/8 arithmetic
  - 0x30 clip: signed a saturated to 0..255
  - 0x34 absolute difference |signed a - signed b|, low WIDTH bits
  - any other code (incl. 0x5, 0x3F): result=0, zero=1, out_valid still pulses
- HI/LO change only on multiply completion or reset.
- Multiply FSM for code 0x13, states IDLE -> MUL -> IDLE:
  - Accept at edge N: latch multiplicand a and multiplier b, clear the 2*WIDTH accumulator, counter=0, busy=1 from edge N.
  - MUL: one shift-add step per cycle; counter increments per step.
  - The WIDTH-th step occurs at edge N+WIDTH. At that edge, write {hi,lo} = a*b (unsigned 64-bit), set result=lo, zero=(lo==0), ovf=0, busy=0, and go to IDLE. out_valid=1 for the cycle following edge N+WIDTH.
  - A new request may be accepted at edge N+WIDTH+1.
- result/zero/ovf hold their value between out_valid pulses.

Test Plan:
- Reset then aluctrl=0x2, a=0x7FFFFFFF, b=0x1 -> next cycle out_valid=1, result=0x80000000, ovf=1, zero=0.
- aluctrl=0x12, b=0x80000000 -> result=0xFF800000. aluctrl=0xF, b=0x80000000 -> result=0x00800000. aluctrl=0x9, b=0x1234 -> 0x12340000.
- aluctrl=0x13, a=b=0xFFFFFFFF -> busy high 32 cycles, in_valid asserted during busy is ignored, out_valid 33 cycles after acceptance, hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001.
- Multiply a=5, b=7, rst=1 at cycle 10 of busy -> busy=0, hi=lo=0, no out_valid; following ADD request completes normally.
- aluctrl=0x30: a=0x123 -> 0xFF; a=0xFFFFFFF0 -> 0x0; a=0x42 -> 0x42. aluctrl=0x34, a=3, b=10 -> 7.
- aluctrl=0x3F, a=b=0xFFFFFFFF -> result=0, zero=1, out_valid=1; hi/lo unchanged.
